pdm_word_pwm_out: RTL and testbench
===================================

// Module: pdm_word_pwm_out
// PURPOSE
//  Audio output stage fed by the PDM-to-word converter's 16-bit audDATA.
//  Per 16-clock frame: latch audDATA, popcount it to a 0..16 duty value and
//  drive a 16-slot PWM waveform plus amplifier shutdown (AUD_SD) on the audio jack.
//  A small FSM sequences amplifier power-up, run and shutdown from `enable`.
// PARAMETERS
//  WORD_W       16  width of audDATA; frame length = WORD_W clocks (power of 2)
//  WARM_FRAMES  4   frames AUD_SD is high with PWM held low before RUN (>=1)
// PORTS
//  clk_2MHz      in   1       sole clock, 2 MHz
//  btnRST        in   1       asynchronous, active-high reset
//  audDATA       in   WORD_W  PDM density word from converter, sampled at frame end
//  enable        in   1       request audio output; level, sampled at frame end
//  AUD_PWM       out  1       PWM audio, registered
//  AUD_SD        out  1       amplifier enable (1 = on), registered
//  frame_strobe  out  1       1-cycle pulse on the cycle where slot == WORD_W-1
//  duty_q        out  5       latched duty of current frame, 0..16
//  active        out  1       1 while FSM in RUN (or RAMP)
// BEHAVIOUR
//  - One clock, one async active-high reset. Reset: slot=0, duty_q=0, state=OFF,
//    AUD_PWM=0, AUD_SD=0, frame_strobe=0, active=0, frame counter=0.
//  - slot: 4-bit free-running counter, +1 every clock, wraps 15->0; runs in all states.
//  - Frame end = edge where slot==15. At that edge: duty_q <= popcount(audDATA)
//    (0..16, 5-bit, no saturation needed); FSM evaluates transitions.
//  - AUD_PWM during cycle with slot==k: 1 iff state==RUN && k < duty_q. Computed from
//    next-state values so the register is correct in the same cycle; latency
//    audDATA sample -> first affected PWM slot = 1 clock (slot 0 of next frame).
//  - duty_q=0 -> PWM low whole frame; duty_q=16 -> PWM high all 16 slots.
//  - FSM (transitions only at frame end):
//    OFF : AUD_SD=0, PWM=0. enable=1 -> WARM, frame counter cleared.
//    WARM: AUD_SD=1, PWM=0, counter +1 per frame. enable=0 -> OFF;
//          counter reaches WARM_FRAMES-1 with enable=1 -> RUN.
//    RUN : AUD_SD=1, PWM per duty, active=1. enable=0 -> OFF (or RAMP, see below).
//  - enable changes mid-frame are ignored until frame end; current frame completes.
//  - audDATA changes mid-frame have no effect until next frame end.
//  - frame_strobe asserted in cycle slot==15, every frame, all states.
//  - Reset mid-frame: all outputs return to reset values immediately (async).
// CONFIGURATION
//  PWM_SOFT_MUTE_EN defined: RUN with enable=0 -> RAMP. RAMP keeps AUD_SD=1,
//    active=1; per frame a 5-bit limit (loaded 16 on entry) decrements by 1;
//    effective duty = min(duty_q, limit). limit reaches 0 -> OFF.
//    enable=1 during RAMP -> RUN (limit ignored). duty_q port = effective duty.
//  Not defined: no RAMP state, RUN -> OFF directly, no limit register.
// TESTING
//  1 Reset then enable=0, audDATA=16'hFFFF for 10 frames -> AUD_SD=0, AUD_PWM=0.
//  2 enable=1 (held), audDATA=16'h00FF -> AUD_SD=1 after 1st frame end, PWM low for
//    4 frames, then RUN: duty_q=8, PWM high slots 0..7, low 8..15 each frame.
//  3 RUN, audDATA 16'h0000 then 16'hFFFF on successive frames -> duty_q 0 then 16;
//    PWM all-low frame then all-high frame; change lands at slot 0 exactly.
//  4 RUN, audDATA=16'hA5A5 toggled to 16'h0001 at slot 7 -> current frame stays
//    duty 8; next frame duty 1 (PWM high slot 0 only).
//  5 RUN, enable=0 at slot 3 -> frame completes; OFF at next frame end (no macro),
//    or with PWM_SOFT_MUTE_EN and duty 16: high-slot counts 16,15,...,1, then OFF.
//  6 btnRST pulse at slot 9 in RUN -> all outputs 0 same cycle; restart enters WARM.

Source files
------------

// File: rtl/pdm_word_pwm_out.sv
// pdm_word_pwm_out: 16-slot PWM audio output with amplifier power sequencing.
// Each frame of WORD_W clocks latches popcount(audDATA) as the duty and drives
// AUD_PWM high for the first duty slots of the next frame while the FSM is in RUN.
// Ports: clk_2MHz clock; btnRST async active-high reset; audDATA density word;
//   enable output request (sampled at frame end); AUD_PWM/AUD_SD registered
//   outputs; frame_strobe marks the last slot; duty_q current duty; active in RUN.
// Optional feature macro PWM_SOFT_MUTE_EN adds a RAMP state that fades the duty
// down one step per frame before shutting the amplifier off.
module pdm_word_pwm_out #(
  parameter int WORD_W      = 16,
  parameter int WARM_FRAMES = 4
) (
  input  logic                           clk_2MHz,
  input  logic                           btnRST,
  input  logic [WORD_W-1:0]              audDATA,
  input  logic                           enable,
  output logic                           AUD_PWM,
  output logic                           AUD_SD,
  output logic                           frame_strobe,
  output logic [$clog2(WORD_W+1)-1:0]    duty_q,
  output logic                           active
);
  localparam int SW = $clog2(WORD_W);
  localparam int DW = $clog2(WORD_W + 1);
  localparam int CW = (WARM_FRAMES > 1) ? $clog2(WARM_FRAMES) : 1;
  typedef enum logic [1:0] {OFF, WARM, RUN, RAMP} state_t;
  state_t          state_q, state_d;
  logic [SW-1:0]   slot_q, slot_d;
  logic [DW-1:0]   raw_q, raw_d, pc, eff_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pwm_q, pwm_d, sd_q, sd_d, fe;
`ifdef PWM_SOFT_MUTE_EN
  logic [DW-1:0]   lim_q, lim_d;
`endif
  always_comb begin
    pc = '0;
    for (int i = 0; i < WORD_W; i++) pc = pc + DW'(audDATA[i]);
  end
  always_comb begin
    fe      = slot_q == SW'(WORD_W - 1);
    slot_d  = slot_q + 1'b1;
    raw_d   = fe ? pc : raw_q;
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef PWM_SOFT_MUTE_EN
    lim_d   = lim_q;
`endif
    if (fe) begin
      case (state_q)
        OFF: if (enable) begin
          state_d = WARM;
          cnt_d   = '0;
        end
        WARM: if (!enable) state_d = OFF;
          else if (cnt_q == CW'(WARM_FRAMES - 1)) state_d = RUN;
          else cnt_d = cnt_q + 1'b1;
`ifdef PWM_SOFT_MUTE_EN
        RUN: if (!enable) begin
          state_d = RAMP;
          lim_d   = DW'(WORD_W);
        end
        RAMP: if (enable) state_d = RUN;
          else if (lim_q == DW'(1)) begin
            state_d = OFF;
            lim_d   = '0;
          end else lim_d = lim_q - 1'b1;
`else
        RUN: if (!enable) state_d = OFF;
`endif
        default: state_d = OFF;
      endcase
    end
    // PWM is derived from next-state values so the registered output lines up
    // with the slot that the counter is about to enter.
`ifdef PWM_SOFT_MUTE_EN
    eff_d = (state_d == RAMP && lim_d < raw_d) ? lim_d : raw_d;
`else
    eff_d = raw_d;
`endif
    pwm_d = (state_d == RUN || state_d == RAMP) && (DW'(slot_d) < eff_d);
    sd_d  = state_d != OFF;
  end
  always_ff @(posedge clk_2MHz or posedge btnRST) begin
    if (btnRST) begin
      state_q <= OFF;
      slot_q  <= '0;
      raw_q   <= '0;
      cnt_q   <= '0;
      pwm_q   <= 1'b0;
      sd_q    <= 1'b0;
`ifdef PWM_SOFT_MUTE_EN
      lim_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      raw_q   <= raw_d;
      cnt_q   <= cnt_d;
      pwm_q   <= pwm_d;
      sd_q    <= sd_d;
`ifdef PWM_SOFT_MUTE_EN
      lim_q   <= lim_d;
`endif
    end
  end
  always_comb begin
`ifdef PWM_SOFT_MUTE_EN
    duty_q = (state_q == RAMP && lim_q < raw_q) ? lim_q : raw_q;
`else
    duty_q = raw_q;
`endif
    AUD_PWM      = pwm_q;
    AUD_SD       = sd_q;
    frame_strobe = fe;
    active       = state_q == RUN || state_q == RAMP;
  end
endmodule

// File: tb/tb_pdm_word_pwm_out.sv
// tb_pdm_word_pwm_out: directed frame vectors checked through a per-frame scoreboard.
module tb_pdm_word_pwm_out;
  logic        clk_2MHz = 1'b0;
  logic        btnRST   = 1'b1;
  logic [15:0] audDATA  = 16'hFFFF;
  logic        enable   = 1'b0;
  logic        AUD_PWM, AUD_SD, frame_strobe, active;
  logic [4:0]  duty_q;
  typedef struct {
    logic [15:0] p;
    logic        s;
    logic [4:0]  d;
    logic        a;
  } exp_t;
  exp_t q[$];
  int cmp = 0;
  int err = 0;
  pdm_word_pwm_out dut (
    .clk_2MHz(clk_2MHz), .btnRST(btnRST), .audDATA(audDATA), .enable(enable),
    .AUD_PWM(AUD_PWM), .AUD_SD(AUD_SD), .frame_strobe(frame_strobe),
    .duty_q(duty_q), .active(active)
  );
  always #5 clk_2MHz = ~clk_2MHz;
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
    cmp++;
    if (got !== want) begin
      err++;
      $display("FAIL %s: got %h want %h", n, got, want);
    end
  endtask
  // one frame: push its expectation at slot 0, change inputs at slot cs
  task automatic frm(input logic e, input logic [15:0] d, input int cs,
                     input logic [15:0] p, input logic s, input logic [4:0] du, input logic a);
    exp_t x;
    x.p = p; x.s = s; x.d = du; x.a = a;
    q.push_back(x);
    for (int k = 0; k < 16; k++) begin
      if (k == cs) begin
        enable  = e;
        audDATA = d;
      end
      @(negedge clk_2MHz);
    end
  endtask
  function automatic logic [15:0] ones(input int n);
    logic [16:0] v;
    v = (17'd1 << n) - 17'd1;
    return v[15:0];
  endfunction
  initial begin
    fork
      begin : monitor
        int ms;
        logic [15:0] pat, sdp;
        exp_t x;
        ms = 0; pat = '0; sdp = '0;
        forever begin
          @(negedge clk_2MHz);
          if (btnRST) begin
            ms = 0; pat = '0; sdp = '0;
          end else begin
            pat[ms[3:0]] = AUD_PWM;
            sdp[ms[3:0]] = AUD_SD;
            if (frame_strobe) begin
              cmp++;
              if (q.size() == 0) begin
                err++;
                $display("FAIL frame: unexpected strobe at t=%0t", $time);
              end else begin
                x = q.pop_front();
                if (pat !== x.p || sdp !== {16{x.s}} || duty_q !== x.d || active !== x.a || ms != 15) begin
                  err++;
                  $display("FAIL frame t=%0t: got pwm=%h sd=%h duty=%0d act=%b len=%0d want pwm=%h sd=%h duty=%0d act=%b len=15",
                           $time, pat, sdp, duty_q, active, ms, x.p, {16{x.s}}, x.d, x.a);
                end
              end
              ms = 0; pat = '0; sdp = '0;
            end else ms++;
          end
        end
      end
    join_none
    repeat (3) @(posedge clk_2MHz);
    @(negedge clk_2MHz);
    chk("reset_outputs", {AUD_PWM, AUD_SD, frame_strobe, duty_q, active}, '0);
    @(posedge clk_2MHz);
    #1 btnRST = 1'b0;
    @(negedge clk_2MHz);
    frm(0, 16'hFFFF, 0, 16'h0000, 0, 0, 0);
    for (int i = 0; i < 9; i++) frm(0, 16'hFFFF, 0, 16'h0000, 0, 16, 0);
    frm(1, 16'h00FF, 0, 16'h0000, 0, 16, 0);
    for (int i = 0; i < 4; i++) frm(1, 16'h00FF, 0, 16'h0000, 1, 8, 0);
    frm(1, 16'h00FF, 0, 16'h00FF, 1, 8, 1);
    frm(1, 16'h0000, 0, 16'h00FF, 1, 8, 1);
    frm(1, 16'hFFFF, 0, 16'h0000, 1, 0, 1);
    frm(1, 16'hA5A5, 0, 16'hFFFF, 1, 16, 1);
    frm(1, 16'h0001, 7, 16'h00FF, 1, 8, 1);
    frm(1, 16'hFFFF, 0, 16'h0001, 1, 1, 1);
    frm(0, 16'hFFFF, 3, 16'hFFFF, 1, 16, 1);
`ifdef PWM_SOFT_MUTE_EN
    for (int n = 16; n >= 1; n--) frm(0, 16'hFFFF, 0, ones(n), 1, 5'(n), 1);
`endif
    frm(1, 16'hFFFF, 0, 16'h0000, 0, 16, 0);
    for (int i = 0; i < 4; i++) frm(1, 16'hFFFF, 0, 16'h0000, 1, 16, 0);
    frm(1, 16'hFFFF, 0, 16'hFFFF, 1, 16, 1);
    repeat (9) @(negedge clk_2MHz);
    chk("run_before_reset", {AUD_PWM, AUD_SD, active}, 3'b111);
    #1 btnRST = 1'b1;
    #1 chk("async_reset", {AUD_PWM, AUD_SD, frame_strobe, duty_q, active}, '0);
    @(posedge clk_2MHz);
    @(posedge clk_2MHz);
    #1 btnRST = 1'b0;
    @(negedge clk_2MHz);
    frm(1, 16'hFFFF, 0, 16'h0000, 0, 0, 0);
    for (int i = 0; i < 4; i++) frm(1, 16'hFFFF, 0, 16'h0000, 1, 16, 0);
    frm(1, 16'hFFFF, 0, 16'hFFFF, 1, 16, 1);
    repeat (2) @(negedge clk_2MHz);
    chk("frames_left", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
